// File: rtl/octo_arb_pkg.sv
// Shared types and helpers for the octo_manager -> UART arbiter.
package octo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    SEND    = 2'd2,
    RELEASE = 2'd3
  } arbState_t;

  localparam int FRAME_W_DEFAULT = 272;

  function automatic int clog2Of(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/octo_uart_arbiter_if.sv
// Bus between the octo_manager bank, the arbiter and the serial transmitter.
// The slave view belongs to the arbiter; the master view drives its inputs.
interface octo_uart_arbiter_if
  import octo_arb_pkg::*;
#(
  parameter int NUM_OCTO = 2,
  parameter int FRAME_W  = FRAME_W_DEFAULT,
  parameter int ID_W     = 3
);

  logic [NUM_OCTO-1:0]         data_avl_in;
  logic [NUM_OCTO*FRAME_W-1:0] sensor_iterations_in;
  logic [NUM_OCTO-1:0]         reset_parser_out;
  logic                        data_avl_out;
  logic [FRAME_W-1:0]          sensor_iterations_out;
  logic [ID_W-1:0]             octo_id;
  logic                        reset_parser_in;
  logic                        busy;
  logic                        drop_timeout_err;

  modport slave (
    input  data_avl_in, sensor_iterations_in, reset_parser_in,
    output reset_parser_out, data_avl_out, sensor_iterations_out,
           octo_id, busy, drop_timeout_err
  );

  modport master (
    output data_avl_in, sensor_iterations_in, reset_parser_in,
    input  reset_parser_out, data_avl_out, sensor_iterations_out,
           octo_id, busy, drop_timeout_err
  );

endinterface

// File: rtl/octo_uart_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: returns the first requester
// found scanning upward from the pointer and wrapping around.
module rr_picker #(
  parameter int NUM_OCTO = 2,
  parameter int ID_W     = 3
) (
  input  logic [NUM_OCTO-1:0] i_req,
  input  logic [ID_W-1:0]     i_rrPtr,
  output logic                o_valid,
  output logic [ID_W-1:0]     o_idx
);

  // Walk the requesters in rotated order; the first hit wins and later hits are ignored
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int i = 0; i < NUM_OCTO; i++) begin
      for (int k = 0; k < NUM_OCTO; k++) begin
        if (!o_valid && (((int'(i_rrPtr) + i) % NUM_OCTO) == k) && i_req[k]) begin
          o_valid = 1'b1;
          o_idx   = ID_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/octo_uart_arbiter.sv
// Round-robin arbiter sharing one serial transmitter among the octo_managers.
// Latches the winner's frame, exports its index and routes the transmitter's
// done strobe back to the granted requester only.
module octo_uart_arbiter
  import octo_arb_pkg::*;
#(
  parameter int NUM_OCTO     = 2,
  parameter int FRAME_W      = FRAME_W_DEFAULT,
  parameter int SYNC_STAGES  = 2,
  parameter int DROP_TIMEOUT = 255,
  parameter int ID_W         = 3
) (
  input logic                clk_12MHz,
  input logic                reset,
  octo_uart_arbiter_if.slave bus
);

  localparam int CNT_W = clog2Of(DROP_TIMEOUT + 1);

  logic [NUM_OCTO-1:0] r_sync [SYNC_STAGES];
  arbState_t           r_state;
  logic [ID_W-1:0]     r_rrPtr;
  logic [ID_W-1:0]     r_octoId;
  logic [FRAME_W-1:0]  r_frame;
  logic                r_dataAvl;
  logic [NUM_OCTO-1:0] r_resetParser;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_err;

  logic [NUM_OCTO-1:0] w_avlS;
  logic                w_pickValid;
  logic [ID_W-1:0]     w_pickIdx;
  logic [FRAME_W-1:0]  w_pickFrame;
  logic [NUM_OCTO-1:0] w_gntOneHot;
  logic                w_avlGnt;
  logic [ID_W-1:0]     w_rrAdvance;

  arbState_t           w_stateNext;
  logic [ID_W-1:0]     w_rrPtrNext;
  logic [ID_W-1:0]     w_octoIdNext;
  logic [FRAME_W-1:0]  w_frameNext;
  logic                w_dataAvlNext;
  logic [NUM_OCTO-1:0] w_resetParserNext;
  logic [CNT_W-1:0]    w_cntNext;
  logic                w_errNext;

  assign w_avlS = r_sync[SYNC_STAGES-1];

  rr_picker #(
    .NUM_OCTO (NUM_OCTO),
    .ID_W     (ID_W)
  ) u_picker (
    .i_req   (w_avlS),
    .i_rrPtr (r_rrPtr),
    .o_valid (w_pickValid),
    .o_idx   (w_pickIdx)
  );

  // Bring each 96 MHz frame-ready level into this domain through a flop chain
  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= bus.data_avl_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  // Select the candidate frame slice and decode the current grant to one-hot
  always_comb begin
    w_pickFrame = '0;
    w_gntOneHot = '0;
    for (int k = 0; k < NUM_OCTO; k++) begin
      if (w_pickIdx == ID_W'(k)) begin
        w_pickFrame = bus.sensor_iterations_in[k*FRAME_W +: FRAME_W];
      end
      w_gntOneHot[k] = (r_octoId == ID_W'(k));
    end
    w_avlGnt    = |(w_avlS & w_gntOneHot);
    w_rrAdvance = (r_octoId == ID_W'(NUM_OCTO - 1)) ? '0 : r_octoId + 1'b1;
  end

  // Next-state and next-output logic; every register holds unless its state says otherwise
  always_comb begin
    w_stateNext       = r_state;
    w_rrPtrNext       = r_rrPtr;
    w_octoIdNext      = r_octoId;
    w_frameNext       = r_frame;
    w_dataAvlNext     = r_dataAvl;
    w_resetParserNext = r_resetParser;
    w_cntNext         = r_cnt;
    w_errNext         = r_err;
    case (r_state)
      IDLE: begin
        if (w_pickValid) begin
          w_octoIdNext = w_pickIdx;
          w_frameNext  = w_pickFrame;
          w_stateNext  = LOAD;
        end
      end
      LOAD: begin
        w_dataAvlNext = 1'b1;
        w_stateNext   = SEND;
      end
      SEND: begin
        if (bus.reset_parser_in) begin
          w_dataAvlNext     = 1'b0;
          w_resetParserNext = w_gntOneHot;
          w_cntNext         = '0;
          w_stateNext       = RELEASE;
        end
      end
      RELEASE: begin
        if (!w_avlGnt) begin
          w_resetParserNext = '0;
          w_rrPtrNext       = w_rrAdvance;
          w_stateNext       = IDLE;
        end else if (r_cnt == CNT_W'(DROP_TIMEOUT - 1)) begin
          w_errNext         = 1'b1;
          w_resetParserNext = '0;
          w_rrPtrNext       = w_rrAdvance;
          w_stateNext       = IDLE;
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transfer without acknowledging it
  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      r_state       <= IDLE;
      r_rrPtr       <= '0;
      r_octoId      <= '0;
      r_frame       <= '0;
      r_dataAvl     <= 1'b0;
      r_resetParser <= '0;
      r_cnt         <= '0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_stateNext;
      r_rrPtr       <= w_rrPtrNext;
      r_octoId      <= w_octoIdNext;
      r_frame       <= w_frameNext;
      r_dataAvl     <= w_dataAvlNext;
      r_resetParser <= w_resetParserNext;
      r_cnt         <= w_cntNext;
      r_err         <= w_errNext;
    end
  end

  assign bus.data_avl_out          = r_dataAvl;
  assign bus.sensor_iterations_out = r_frame;
  assign bus.octo_id               = r_octoId;
  assign bus.reset_parser_out      = r_resetParser;
  assign bus.drop_timeout_err      = r_err;
  assign bus.busy                  = (r_state != IDLE);

endmodule

// File: tb/tb_octo_uart_arbiter.sv
// Directed bench for octo_uart_arbiter with two requesters and a short drop timeout.
module tb_octo_uart_arbiter;

  localparam int NUM_OCTO     = 2;
  localparam int FRAME_W      = 272;
  localparam int SYNC_STAGES  = 2;
  localparam int DROP_TIMEOUT = 16;
  localparam int ID_W         = 3;

  localparam logic [FRAME_W-1:0] FRAME0 = {34{8'h3C}};
  localparam logic [FRAME_W-1:0] FRAME1 = {34{8'hA5}};

  logic clk_12MHz;
  logic reset;
  int   checks;
  int   failures;

  octo_uart_arbiter_if #(
    .NUM_OCTO (NUM_OCTO),
    .FRAME_W  (FRAME_W),
    .ID_W     (ID_W)
  ) bus ();

  octo_uart_arbiter #(
    .NUM_OCTO     (NUM_OCTO),
    .FRAME_W      (FRAME_W),
    .SYNC_STAGES  (SYNC_STAGES),
    .DROP_TIMEOUT (DROP_TIMEOUT),
    .ID_W         (ID_W)
  ) dut (
    .clk_12MHz (clk_12MHz),
    .reset     (reset),
    .bus       (bus)
  );

  // Free-running 12 MHz-style clock
  initial begin
    clk_12MHz = 1'b0;
    forever #5 clk_12MHz = ~clk_12MHz;
  end

  // Absolute time limit so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_12MHz);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [NUM_OCTO-1:0] avl, input logic ack);
    bus.data_avl_in     = avl;
    bus.reset_parser_in = ack;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkFrame(input string tag, input logic [FRAME_W-1:0] observed, input logic [FRAME_W-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Linear sequence of directed steps; outputs are sampled 1 time unit after each rising edge
  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.sensor_iterations_in = {FRAME1, FRAME0};
    applyStimulus(2'b00, 1'b0);
    tick(2);
    checkOutput("rst_dao",   8'(bus.data_avl_out),     8'h00);
    checkOutput("rst_rpo",   8'(bus.reset_parser_out), 8'h00);
    checkOutput("rst_id",    8'(bus.octo_id),          8'h00);
    checkOutput("rst_busy",  8'(bus.busy),             8'h00);
    checkOutput("rst_err",   8'(bus.drop_timeout_err), 8'h00);
    checkFrame ("rst_frame", bus.sensor_iterations_out, '0);
    reset = 1'b0;
    tick(1);

    applyStimulus(2'b10, 1'b0);
    tick(3);
    checkOutput("single_load_dao",  8'(bus.data_avl_out), 8'h00);
    checkOutput("single_load_busy", 8'(bus.busy),         8'h01);
    tick(1);
    checkOutput("single_dao",   8'(bus.data_avl_out), 8'h01);
    checkOutput("single_id",    8'(bus.octo_id),      8'h01);
    checkFrame ("single_frame", bus.sensor_iterations_out, FRAME1);
    applyStimulus(2'b10, 1'b1);
    tick(1);
    checkOutput("single_ack_rpo", 8'(bus.reset_parser_out), 8'h02);
    checkOutput("single_ack_dao", 8'(bus.data_avl_out),     8'h00);
    applyStimulus(2'b00, 1'b0);
    tick(2);
    checkOutput("single_hold_rpo",  8'(bus.reset_parser_out), 8'h02);
    checkOutput("single_hold_busy", 8'(bus.busy),             8'h01);
    tick(1);
    checkOutput("single_done_rpo",  8'(bus.reset_parser_out), 8'h00);
    checkOutput("single_done_busy", 8'(bus.busy),             8'h00);

    applyStimulus(2'b00, 1'b1);
    tick(1);
    applyStimulus(2'b00, 1'b0);
    tick(1);
    checkOutput("spur_busy",  8'(bus.busy),             8'h00);
    checkOutput("spur_dao",   8'(bus.data_avl_out),     8'h00);
    checkOutput("spur_rpo",   8'(bus.reset_parser_out), 8'h00);
    checkOutput("spur_id",    8'(bus.octo_id),          8'h01);
    checkFrame ("spur_frame", bus.sensor_iterations_out, FRAME1);

    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checkOutput("rst2_id", 8'(bus.octo_id), 8'h00);
    applyStimulus(2'b11, 1'b0);
    tick(4);
    checkOutput("cont_a_dao",   8'(bus.data_avl_out), 8'h01);
    checkOutput("cont_a_id",    8'(bus.octo_id),      8'h00);
    checkFrame ("cont_a_frame", bus.sensor_iterations_out, FRAME0);
    applyStimulus(2'b11, 1'b1);
    tick(1);
    checkOutput("cont_a_rpo", 8'(bus.reset_parser_out), 8'h01);
    applyStimulus(2'b10, 1'b0);
    tick(3);
    checkOutput("cont_a_done_rpo",  8'(bus.reset_parser_out), 8'h00);
    checkOutput("cont_a_done_busy", 8'(bus.busy),             8'h00);
    tick(2);
    checkOutput("cont_b_dao",   8'(bus.data_avl_out), 8'h01);
    checkOutput("cont_b_id",    8'(bus.octo_id),      8'h01);
    checkFrame ("cont_b_frame", bus.sensor_iterations_out, FRAME1);
    applyStimulus(2'b11, 1'b0);
    tick(3);
    checkOutput("cont_b_hold_dao", 8'(bus.data_avl_out), 8'h01);
    applyStimulus(2'b11, 1'b1);
    tick(1);
    checkOutput("cont_b_rpo", 8'(bus.reset_parser_out), 8'h02);
    applyStimulus(2'b01, 1'b0);
    tick(3);
    checkOutput("cont_b_done_busy", 8'(bus.busy),             8'h00);
    checkOutput("cont_b_done_rpo",  8'(bus.reset_parser_out), 8'h00);
    tick(2);
    checkOutput("cont_c_dao", 8'(bus.data_avl_out), 8'h01);
    checkOutput("cont_c_id",  8'(bus.octo_id),      8'h00);

    for (int i = 0; i < 4; i++) begin
      bus.sensor_iterations_in[FRAME_W-1:0] = {34{8'(i * 17 + 1)}};
      tick(1);
      checkFrame ("stable_frame", bus.sensor_iterations_out, FRAME0);
      checkOutput("stable_dao",   8'(bus.data_avl_out),     8'h01);
    end
    bus.sensor_iterations_in[FRAME_W-1:0] = FRAME0;

    applyStimulus(2'b01, 1'b1);
    tick(1);
    checkOutput("drop_ack_rpo", 8'(bus.reset_parser_out), 8'h01);
    applyStimulus(2'b01, 1'b0);
    tick(15);
    checkOutput("drop_pre_rpo",  8'(bus.reset_parser_out), 8'h01);
    checkOutput("drop_pre_err",  8'(bus.drop_timeout_err), 8'h00);
    checkOutput("drop_pre_busy", 8'(bus.busy),             8'h01);
    tick(1);
    checkOutput("drop_err",  8'(bus.drop_timeout_err), 8'h01);
    checkOutput("drop_rpo",  8'(bus.reset_parser_out), 8'h00);
    checkOutput("drop_busy", 8'(bus.busy),             8'h00);
    tick(1);
    checkOutput("drop_regrant_busy", 8'(bus.busy), 8'h01);
    tick(1);
    checkOutput("drop_regrant_dao", 8'(bus.data_avl_out),     8'h01);
    checkOutput("drop_regrant_id",  8'(bus.octo_id),          8'h00);
    checkOutput("drop_err_sticky",  8'(bus.drop_timeout_err), 8'h01);

    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checkOutput("midrst_dao",   8'(bus.data_avl_out),     8'h00);
    checkOutput("midrst_rpo",   8'(bus.reset_parser_out), 8'h00);
    checkOutput("midrst_busy",  8'(bus.busy),             8'h00);
    checkOutput("midrst_err",   8'(bus.drop_timeout_err), 8'h00);
    checkFrame ("midrst_frame", bus.sensor_iterations_out, '0);
    tick(3);
    checkOutput("midrst_load_dao",  8'(bus.data_avl_out),     8'h00);
    checkOutput("midrst_load_rpo",  8'(bus.reset_parser_out), 8'h00);
    checkOutput("midrst_load_busy", 8'(bus.busy),             8'h01);
    tick(1);
    checkOutput("midrst_regrant_dao", 8'(bus.data_avl_out), 8'h01);
    checkOutput("midrst_regrant_id",  8'(bus.octo_id),      8'h00);
    checkFrame ("midrst_regrant_frame", bus.sensor_iterations_out, FRAME0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
